led_pwm_ctrl: RTL and testbench
===============================

LED_PWM_CTRL -- requirements
Module: led_pwm_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of PWM output channels (1..16).
REQ-002 SHALL have parameter PWM_BITS, default 8, PWM counter width; period = 2^PWM_BITS ticks.
REQ-003 SHALL have parameter PRESCALE_BITS, default 16, prescaler register width.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1; 1 means output pins are driven low when a channel is on.
REQ-005 SHALL have port clk, input, 1, single clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port wr_en, input, 1, register write strobe.
REQ-008 SHALL have port rd_en, input, 1, register read strobe.
REQ-009 SHALL have port addr, input, 5, word register index.
REQ-010 SHALL have port wdata, input, 32, write data.
REQ-011 SHALL have port rdata, output, 32, registered read data.
REQ-012 SHALL have port rd_valid, output, 1, one-cycle pulse qualifying rdata.
REQ-013 SHALL have port pwm_out, output, NUM_CH, channel pins, polarity per ACTIVE_LOW.
REQ-014 SHALL have port period_tick, output, 1, one-cycle pulse at each PWM period wrap.

Function
REQ-015 SHALL decode registers as follows: addr 0 CTRL (bit0 enable, bit1 blink); addr 1 PRESCALE (PRESCALE_BITS); addr 2 BLINK_LEN (8 bits); addr 16+i DUTY[i] shadow (PWM_BITS+1 bits), for i < NUM_CH.
REQ-016 SHALL ignore writes to unmapped addresses and truncate wdata to the register width.
REQ-017 SHALL answer rd_en one cycle later, with rd_valid=1 and rdata holding the register zero-extended; unmapped reads SHALL return 0.
REQ-018 SHALL return the pre-write value when rd_en and wr_en target the same address in the same cycle.
REQ-019 SHALL, with the prescaler counter running 0..PRESCALE, assert an internal tick when the counter equals PRESCALE and then return it to 0; PRESCALE=0 SHALL give a tick every cycle.
REQ-020 SHALL advance the PWM counter by 1 on each tick, wrapping from 2^PWM_BITS-1 to 0.
REQ-021 SHALL pulse period_tick for the cycle in which the wrapping tick occurs.
REQ-022 SHALL load every active duty from its shadow on the wrap edge, using the shadow value present before that edge; a shadow write in the same cycle SHALL take effect one period later.
REQ-023 SHALL set channel i on when the PWM counter < active duty[i]; duty 0 SHALL be always off, and duty >= 2^PWM_BITS SHALL be always on.
REQ-024 SHALL, when blink=1, count period wraps; when the count reaches BLINK_LEN, the block SHALL toggle blink_phase and clear the count; BLINK_LEN=0 SHALL toggle on every wrap.
REQ-025 SHALL gate channel on-state with blink_phase when blink=1, and SHALL ignore blink_phase when blink=0.
REQ-026 SHALL, while enable=0, hold the prescaler, PWM counter and blink count at 0, set blink_phase=1, copy shadows to active duties every cycle, force all channels off, and hold period_tick at 0.
REQ-027 SHALL, when enable goes 0->1, start counting from 0 on the next cycle, so that the first period is a full 2^PWM_BITS ticks.
REQ-028 SHALL register pwm_out, so the pin reflects the counter comparison with one cycle of latency.
REQ-029 SHALL drive pin = on XOR ACTIVE_LOW.

Reset
REQ-030 SHALL, on reset, clear CTRL, PRESCALE, BLINK_LEN, all shadow and active duties, all counters, rdata, rd_valid and period_tick, and set blink_phase=1.
REQ-031 SHALL hold pwm_out at the inactive level (all 1s if ACTIVE_LOW=1) during and after reset until the block is enabled.
REQ-032 SHALL, when reset is asserted mid-period, abandon the period immediately, with no period_tick pulse.

Verification
REQ-033 SHALL be verified by: NUM_CH=4, PWM_BITS=8, PRESCALE=0, DUTY[0]=64, enable -> ch0 on for exactly 64 of every 256 cycles and period_tick every 256 cycles.
REQ-034 SHALL be verified by: PRESCALE=3, DUTY[1]=256 -> ch1 always on and period_tick every 1024 cycles; DUTY[1]=0 -> ch1 always off from the next period.
REQ-035 SHALL be verified by: DUTY[2] written 32->200 in the wrap cycle -> next period still uses 32 and the following period uses 200.
REQ-036 SHALL be verified by: blink=1, BLINK_LEN=1, DUTY[3]=128 -> ch3 pulses for 2 periods, then stays off for 2 periods, repeating.
REQ-037 SHALL be verified by: read addr 16 with a simultaneous write of 5 -> rd_valid next cycle with the old value, and a subsequent read returns 5; a read of addr 9 returns 0.
REQ-038 SHALL be verified by: reset asserted mid-period while ACTIVE_LOW=1 -> pwm_out=4'b1111 in the same cycle and all registers read 0.

Source files
------------

// File: rtl/led_pwm_ctrl.sv
// rtl/led_pwm_ctrl.sv - multi-channel LED PWM controller with prescaler, shadowed duties and blink
//
// Purpose: NUM_CH PWM channels share a PWM_BITS counter advanced by a
// programmable prescaler tick. Duty cycles are double-buffered (shadow ->
// active on each period wrap), and an optional blink gate switches all
// channels on/off every BLINK_LEN+1 periods.
//
// Ports:
//   clk, reset        single clock, asynchronous active-high reset
//   wr_en, rd_en      register write / read strobes
//   addr, wdata       word register index and write data
//   rdata, rd_valid   registered read data, qualified one cycle after rd_en
//   pwm_out           registered channel pins (on XOR ACTIVE_LOW)
//   period_tick       one-cycle pulse per PWM period wrap
module led_pwm_ctrl #(
    parameter int NUM_CH        = 4,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE_BITS = 16,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [4:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rd_valid,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick
);

    localparam logic [NUM_CH-1:0] IDLE_PINS = {NUM_CH{ACTIVE_LOW}};

    logic [1:0]               ctrl_q, ctrl_d;
    logic [PRESCALE_BITS-1:0] prescale_q, prescale_d;
    logic [7:0]               blink_len_q, blink_len_d;
    logic [PWM_BITS:0]        shadow_q [NUM_CH];
    logic [PWM_BITS:0]        shadow_d [NUM_CH];
    logic [PWM_BITS:0]        active_q [NUM_CH];
    logic [PWM_BITS:0]        active_d [NUM_CH];
    logic [PRESCALE_BITS-1:0] pre_cnt_q, pre_cnt_d;
    logic [PWM_BITS-1:0]      pwm_cnt_q, pwm_cnt_d;
    logic [7:0]               blink_cnt_q, blink_cnt_d;
    logic                     blink_phase_q, blink_phase_d;
    logic [NUM_CH-1:0]        pwm_out_q, pwm_out_d;
    logic                     period_tick_q, period_tick_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     rd_valid_q, rd_valid_d;

    logic              enable;
    logic              blink;
    logic              tick;
    logic              wrap;
    logic [NUM_CH-1:0] on;

    assign enable = ctrl_q[0];
    assign blink  = ctrl_q[1];

    always_comb begin
        ctrl_d        = ctrl_q;
        prescale_d    = prescale_q;
        blink_len_d   = blink_len_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        pre_cnt_d     = pre_cnt_q;
        pwm_cnt_d     = pwm_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        rdata_d       = rdata_q;
        rd_valid_d    = rd_en;
        tick          = 1'b0;
        wrap          = 1'b0;
        on            = '0;

        // Reads sample the current (pre-write) register state.
        if (rd_en) begin
            rdata_d = '0;
            case (addr)
                5'd0: rdata_d = 32'(ctrl_q);
                5'd1: rdata_d = 32'(prescale_q);
                5'd2: rdata_d = 32'(blink_len_q);
                default: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (addr == 5'(16 + i)) rdata_d = 32'(shadow_q[i]);
                    end
                end
            endcase
        end

        if (wr_en) begin
            case (addr)
                5'd0: ctrl_d      = wdata[1:0];
                5'd1: prescale_d  = wdata[PRESCALE_BITS-1:0];
                5'd2: blink_len_d = wdata[7:0];
                default: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (addr == 5'(16 + i)) shadow_d[i] = wdata[PWM_BITS:0];
                    end
                end
            endcase
        end

        if (!enable) begin
            pre_cnt_d     = '0;
            pwm_cnt_d     = '0;
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
            active_d      = shadow_q;
        end else begin
            // >= keeps the prescaler from running the long way round if
            // PRESCALE is lowered below the current count.
            tick      = (pre_cnt_q >= prescale_q);
            pre_cnt_d = tick ? '0 : pre_cnt_q + PRESCALE_BITS'(1);
            if (tick) pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
            wrap = tick && (pwm_cnt_q == '1);
            if (wrap) begin
                active_d = shadow_q;
                if (blink) begin
                    if (blink_cnt_q == blink_len_q) begin
                        blink_phase_d = ~blink_phase_q;
                        blink_cnt_d   = '0;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 8'd1;
                    end
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                on[i] = ({1'b0, pwm_cnt_q} < active_q[i]) && (!blink || blink_phase_q);
            end
        end

        period_tick_d = wrap;
        pwm_out_d     = on ^ IDLE_PINS;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q        <= '0;
            prescale_q    <= '0;
            blink_len_q   <= '0;
            shadow_q      <= '{default: '0};
            active_q      <= '{default: '0};
            pre_cnt_q     <= '0;
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            pwm_out_q     <= IDLE_PINS;
            period_tick_q <= 1'b0;
            rdata_q       <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            ctrl_q        <= ctrl_d;
            prescale_q    <= prescale_d;
            blink_len_q   <= blink_len_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pre_cnt_q     <= pre_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pwm_out_q     <= pwm_out_d;
            period_tick_q <= period_tick_d;
            rdata_q       <= rdata_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    assign rdata       = rdata_q;
    assign rd_valid    = rd_valid_q;
    assign pwm_out     = pwm_out_q;
    assign period_tick = period_tick_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// tb/tb_led_pwm_ctrl.sv - scoreboard bench for led_pwm_ctrl
module tb_led_pwm_ctrl;

    localparam bit ACT_LOW = 1'b1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rd_valid;
    logic [3:0]  pwm_out;
    logic        period_tick;

    int pass_cnt = 0;
    int total_cnt = 0;

    int rd_q[$];
    int on_q[$];
    int len_q[$];

    led_pwm_ctrl #(
        .NUM_CH(4), .PWM_BITS(8), .PRESCALE_BITS(16), .ACTIVE_LOW(ACT_LOW)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid), .pwm_out(pwm_out),
        .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic reg_read(input logic [4:0] a, input int exp);
        int e;
        rd_q.push_back(exp);
        @(posedge clk); #1;
        rd_en = 1'b1; addr = a;
        @(posedge clk); #1;
        rd_en = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (rd_valid !== 1'b1) $display("FAIL rd_valid addr=%0d got=%b exp=1", a, rd_valid);
        else pass_cnt++;
        e = rd_q.pop_front();
        total_cnt++;
        if (rdata !== 32'(e)) $display("FAIL rdata addr=%0d got=%0h exp=%0h", a, rdata, e);
        else pass_cnt++;
    endtask

    // Waits for a period_tick, then measures nper full periods of channel ch.
    task automatic measure(input int ch, input int nper);
        int  on_cnt, len, e_on, e_len;
        bit  seen;
        seen = 1'b0;
        for (int c = 0; c < 5000 && !seen; c++) begin
            @(negedge clk);
            if (period_tick === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            total_cnt++;
            $display("FAIL period_tick_timeout ch=%0d got=none exp=pulse", ch);
            for (int p = 0; p < nper; p++) begin
                void'(on_q.pop_front());
                void'(len_q.pop_front());
            end
            return;
        end
        for (int p = 0; p < nper; p++) begin
            on_cnt = 0; len = 0; seen = 1'b0;
            while (!seen && len < 5000) begin
                @(negedge clk);
                len++;
                if ((pwm_out[ch] ^ ACT_LOW) === 1'b1) on_cnt++;
                if (period_tick === 1'b1) seen = 1'b1;
            end
            e_on  = on_q.pop_front();
            e_len = len_q.pop_front();
            total_cnt++;
            if (on_cnt !== e_on) $display("FAIL on_count ch=%0d period=%0d got=%0d exp=%0d", ch, p, on_cnt, e_on);
            else pass_cnt++;
            total_cnt++;
            if (len !== e_len) $display("FAIL period_len ch=%0d period=%0d got=%0d exp=%0d", ch, p, len, e_len);
            else pass_cnt++;
        end
    endtask

    task automatic expect_period(input int on_cycles, input int len);
        on_q.push_back(on_cycles);
        len_q.push_back(len);
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (pwm_out !== 4'hF) $display("FAIL reset_pins got=%b exp=1111", pwm_out);
        else pass_cnt++;
        total_cnt++;
        if ({period_tick, rd_valid} !== 2'b00) $display("FAIL reset_pulses got=%b exp=00", {period_tick, rd_valid});
        else pass_cnt++;
        total_cnt++;
        if (rdata !== 32'h0) $display("FAIL reset_rdata got=%0h exp=0", rdata);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
        reg_read(5'd0, 0);
        reg_read(5'd1, 0);
        reg_read(5'd2, 0);
        for (int i = 0; i < 4; i++) reg_read(5'(16 + i), 0);
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (period_tick !== 1'b0 || pwm_out !== 4'hF) bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL idle_after_reset bad_cycles got=%0d exp=0", bad);
        else pass_cnt++;
    endtask

    task automatic test_duty_basic();
        int  on_cnt;
        bit  seen;
        reg_write(5'd16, 32'd64);
        reg_write(5'd0, 32'd1);
        on_cnt = 0; seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge clk);
            if (pwm_out[0] === 1'b0) on_cnt++;
            if (period_tick === 1'b1) seen = 1'b1;
        end
        total_cnt++;
        if (!seen || on_cnt !== 64) $display("FAIL first_period_on got=%0d seen=%b exp=64", on_cnt, seen);
        else pass_cnt++;
        expect_period(64, 256);
        expect_period(64, 256);
        measure(0, 2);
        expect_period(0, 256);
        measure(1, 1);
    endtask

    task automatic test_prescale();
        reg_write(5'd0, 32'd0);
        reg_write(5'd1, 32'd3);
        reg_write(5'd17, 32'd256);
        reg_write(5'd0, 32'd1);
        expect_period(1024, 1024);
        expect_period(1024, 1024);
        measure(1, 2);
        reg_write(5'd17, 32'd0);
        expect_period(0, 1024);
        measure(1, 1);
    endtask

    task automatic test_shadow_wrap();
        bit seen;
        reg_write(5'd0, 32'd0);
        reg_write(5'd1, 32'd0);
        reg_write(5'd18, 32'd32);
        reg_write(5'd0, 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge clk);
            if (period_tick === 1'b1) seen = 1'b1;
        end
        total_cnt++;
        if (!seen) $display("FAIL shadow_sync got=none exp=period_tick");
        else pass_cnt++;
        // Land the write on the cycle whose closing edge is the next wrap.
        repeat (255) @(posedge clk);
        #1;
        wr_en = 1'b1; addr = 5'd18; wdata = 32'd200;
        @(posedge clk); #1;
        wr_en = 1'b0;
        expect_period(32, 256);
        expect_period(200, 256);
        measure(2, 2);
    endtask

    task automatic test_blink();
        reg_write(5'd0, 32'd0);
        reg_write(5'd19, 32'd128);
        reg_write(5'd2, 32'd1);
        reg_write(5'd0, 32'd3);
        expect_period(128, 256);
        expect_period(0, 256);
        expect_period(0, 256);
        expect_period(128, 256);
        expect_period(128, 256);
        expect_period(0, 256);
        measure(3, 6);
    endtask

    task automatic test_back_to_back_rw();
        int e;
        rd_q.push_back(64);
        @(posedge clk); #1;
        rd_en = 1'b1; wr_en = 1'b1; addr = 5'd16; wdata = 32'd5;
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (rd_valid !== 1'b1) $display("FAIL rw_same_valid got=%b exp=1", rd_valid);
        else pass_cnt++;
        e = rd_q.pop_front();
        total_cnt++;
        if (rdata !== 32'(e)) $display("FAIL rw_same_old got=%0d exp=%0d", rdata, e);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (rd_valid !== 1'b0) $display("FAIL rd_valid_pulse got=%b exp=0", rd_valid);
        else pass_cnt++;
        reg_read(5'd16, 5);
        reg_read(5'd9, 0);
        reg_write(5'd9, 32'hDEADBEEF);
        reg_read(5'd9, 0);
        reg_write(5'd1, 32'hFFFF1234);
        reg_read(5'd1, 32'h1234);
        reg_read(5'd0, 3);
        reg_read(5'd2, 1);
        reg_write(5'd2, 32'h0000_0A05);
        reg_read(5'd2, 5);
        reg_read(5'd17, 0);
        reg_read(5'd18, 200);
        reg_read(5'd19, 128);
    endtask

    task automatic test_reset_mid();
        bit seen;
        int bad;
        reg_write(5'd1, 32'd0);
        reg_write(5'd0, 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (period_tick === 1'b1) seen = 1'b1;
        end
        @(negedge clk);
        // Counter at 0: ch0 (5), ch2 (200), ch3 (128) on; ch1 (0) off.
        total_cnt++;
        if (!seen || pwm_out !== 4'b0010) $display("FAIL pre_reset_pins got=%b seen=%b exp=0010", pwm_out, seen);
        else pass_cnt++;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (pwm_out !== 4'hF) $display("FAIL mid_reset_pins got=%b exp=1111", pwm_out);
        else pass_cnt++;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (period_tick !== 1'b0 || pwm_out !== 4'hF || rd_valid !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL mid_reset_hold bad_cycles got=%0d exp=0", bad);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
        reg_read(5'd0, 0);
        reg_read(5'd1, 0);
        reg_read(5'd2, 0);
        for (int i = 0; i < 4; i++) reg_read(5'(16 + i), 0);
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (period_tick !== 1'b0 || pwm_out !== 4'hF) bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL post_reset_idle bad_cycles got=%0d exp=0", bad);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_duty_basic();
        test_prescale();
        test_shadow_wrap();
        test_blink();
        test_back_to_back_rw();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
